// File: rtl/fp_mul_rs.sv
// Reservation station and issue scheduler feeding a shared combinational FP32 multiplier.
// Optional oldest-first selection is enabled with `define FPM_RS_AGE_ORDER_EN.
module fp_mul_rs #(
  parameter int ENTRIES  = 4,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic             disp_j_rdy,
  input  logic             disp_k_rdy,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  output logic [TAG_W-1:0] disp_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_data,
  output logic [3:0]       busy_cnt
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] busy, j_rdy, k_rdy;
  logic [TAG_W-1:0]   qj [ENTRIES];
  logic [TAG_W-1:0]   qk [ENTRIES];
  logic [31:0]        vj [ENTRIES];
  logic [31:0]        vk [ENTRIES];

  logic [ENTRIES-1:0] ready_vec, alloc, wake_j, wake_k, sel_oh, free_oh;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic               free_any, any_ready;
  logic               disp_ok, cdb_hit, fwd_j, fwd_k;
  logic               w_adv, x_adv, issue;
  logic               x_vld_p1;
  logic [TAG_W-1:0]   x_tag_p1;

`ifdef FPM_RS_AGE_ORDER_EN
  logic [IDX_W-1:0]   rank [ENTRIES];
  logic [IDX_W-1:0]   best;
`endif

  always_comb begin
    free_oh  = '0;
    free_idx = '0;
    free_any = 1'b0;
    busy_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      busy_cnt = busy_cnt + {3'b000, busy[i]};
      if (!busy[i] && !free_any) begin
        free_oh[i] = 1'b1;
        free_idx   = IDX_W'(i);
        free_any   = 1'b1;
      end
    end
  end

  assign disp_ready = free_any;
  assign disp_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
  assign disp_ok    = disp_valid & disp_ready & ~flush;
  assign cdb_hit    = cdb_valid & ~flush;
  assign fwd_j      = cdb_hit & ~disp_j_rdy & (disp_qj == cdb_tag);
  assign fwd_k      = cdb_hit & ~disp_k_rdy & (disp_qk == cdb_tag);
  assign ready_vec  = busy & j_rdy & k_rdy;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      alloc[i]  = disp_ok & free_oh[i];
      wake_j[i] = cdb_hit & busy[i] & ~j_rdy[i] & (qj[i] == cdb_tag);
      wake_k[i] = cdb_hit & busy[i] & ~k_rdy[i] & (qk[i] == cdb_tag);
    end
  end

  always_comb begin
    sel_idx   = '0;
    any_ready = 1'b0;
    sel_oh    = '0;
`ifdef FPM_RS_AGE_ORDER_EN
    // Smallest rank is the oldest resident entry.
    best = '1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready_vec[i] && (!any_ready || rank[i] < best)) begin
        sel_idx   = IDX_W'(i);
        best      = rank[i];
        any_ready = 1'b1;
      end
    end
`else
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready_vec[i] && !any_ready) begin
        sel_idx   = IDX_W'(i);
        any_ready = 1'b1;
      end
    end
`endif
    for (int i = 0; i < ENTRIES; i++)
      sel_oh[i] = any_ready & (sel_idx == IDX_W'(i));
  end

  assign w_adv = ~res_valid | res_ready;
  assign x_adv = ~x_vld_p1 | w_adv;
  assign issue = any_ready & x_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= '0;
      j_rdy <= '0;
      k_rdy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (issue && sel_oh[i]) begin
          busy[i] <= 1'b0;
        end else if (alloc[i]) begin
          busy[i]  <= 1'b1;
          j_rdy[i] <= disp_j_rdy | fwd_j;
          k_rdy[i] <= disp_k_rdy | fwd_k;
        end else begin
          if (wake_j[i]) j_rdy[i] <= 1'b1;
          if (wake_k[i]) k_rdy[i] <= 1'b1;
        end
      end
    end
  end

  // Operand storage carries no reset; its rdy flags qualify it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (alloc[i]) begin
        qj[i] <= disp_qj;
        qk[i] <= disp_qk;
        vj[i] <= fwd_j ? cdb_data : disp_vj;
        vk[i] <= fwd_k ? cdb_data : disp_vk;
      end else begin
        if (wake_j[i]) vj[i] <= cdb_data;
        if (wake_k[i]) vk[i] <= cdb_data;
      end
    end
  end

`ifdef FPM_RS_AGE_ORDER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) rank[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) rank[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc[i])
          rank[i] <= IDX_W'(busy_cnt - {3'b000, issue});
        else if (issue && busy[i] && rank[i] > rank[sel_idx])
          rank[i] <= rank[i] - 1'b1;
      end
    end
  end
`endif

  // X stage (p1) operand register, then W stage (p2) result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_vld_p1  <= 1'b0;
      x_tag_p1  <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_data  <= '0;
    end else if (flush) begin
      x_vld_p1  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (w_adv) begin
        res_valid <= x_vld_p1;
        if (x_vld_p1) begin
          res_data <= mul_p;
          res_tag  <= x_tag_p1;
        end
      end
      if (x_adv) begin
        x_vld_p1 <= issue;
        if (issue) begin
          mul_a    <= vj[sel_idx];
          mul_b    <= vk[sel_idx];
          x_tag_p1 <= TAG_W'(TAG_BASE) + TAG_W'(sel_idx);
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_rs.sv
// Self-checking bench for fp_mul_rs: directed timing cases plus randomized traffic
// scored per instruction against a behavioural FP32 multiply model.
module tb_fp_mul_rs;
  localparam int ENTRIES = 4, TAG_W = 4, TAG_BASE = 8;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic disp_valid = 1'b0, disp_ready, disp_j_rdy = 1'b0, disp_k_rdy = 1'b0;
  logic [TAG_W-1:0] disp_qj = '0, disp_qk = '0, disp_tag;
  logic [31:0] disp_vj = '0, disp_vk = '0;
  logic cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic [31:0] mul_a, mul_b, mul_p, res_data;
  logic res_valid, res_ready = 1'b0;
  logic [TAG_W-1:0] res_tag;
  logic [3:0] busy_cnt;

  fp_mul_rs #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .TAG_BASE(TAG_BASE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_j_rdy(disp_j_rdy), .disp_k_rdy(disp_k_rdy),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // Truncating FP32 multiply for normal operands.
  function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int e;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; e = e + 1; end
    else m = p[45:23];
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  assign mul_p = fpmul(mul_a, mul_b);

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
  endtask

  task automatic dispatch(input logic jr, input logic kr, input logic [3:0] qj, input logic [3:0] qk,
                          input logic [31:0] vj, input logic [31:0] vk);
    disp_valid = 1'b1; disp_j_rdy = jr; disp_k_rdy = kr;
    disp_qj = qj; disp_qk = qk; disp_vj = vj; disp_vk = vk;
  endtask

  task automatic bcast(input logic [3:0] t, input logic [31:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    r = $urandom;
    return {r[31], 8'(100 + $urandom_range(50)), r[22:0]};
  endfunction

  // Scoreboard: one record per accepted instruction, in dispatch order.
  typedef struct {
    logic [3:0]  tag;
    logic        jok, kok;
    logic [3:0]  qj, qk;
    logic [31:0] vj, vk;
  } rec_t;
  rec_t pend[$];
  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      rec_t r;
      int hit;
      if (res_valid && res_ready) begin
        hit = -1;
        for (int i = 0; i < pend.size(); i++)
          if (hit < 0 && pend[i].tag == res_tag) hit = i;
        check("rnd_match", 32'(hit >= 0), 32'd1);
        if (hit >= 0) begin
          r = pend[hit];
          check("rnd_resolved", 32'(r.jok & r.kok), 32'd1);
          check("rnd_data", res_data, fpmul(r.vj, r.vk));
          pend.delete(hit);
        end
      end
      if (cdb_valid) begin
        for (int i = 0; i < pend.size(); i++) begin
          r = pend[i];
          if (!r.jok && r.qj == cdb_tag) begin r.jok = 1'b1; r.vj = cdb_data; end
          if (!r.kok && r.qk == cdb_tag) begin r.kok = 1'b1; r.vk = cdb_data; end
          pend[i] = r;
        end
      end
      if (disp_valid && disp_ready) begin
        r.tag = disp_tag; r.qj = disp_qj; r.qk = disp_qk;
        r.jok = disp_j_rdy; r.vj = disp_vj; r.kok = disp_k_rdy; r.vk = disp_vk;
        if (!r.jok && cdb_valid && r.qj == cdb_tag) begin r.jok = 1'b1; r.vj = cdb_data; end
        if (!r.kok && cdb_valid && r.qk == cdb_tag) begin r.kok = 1'b1; r.vk = cdb_data; end
        pend.push_back(r);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] vk_tab [4];
  logic [3:0]  first_tag, second_tag;
  logic [31:0] first_data, second_data;

  initial begin
    step(2);
    check("rst_disp_ready", 32'(disp_ready), 32'd1);
    check("rst_disp_tag", 32'(disp_tag), 32'd8);
    check("rst_busy_cnt", 32'(busy_cnt), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_mul_b", mul_b, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_tag", 32'(res_tag), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic multiply at minimum latency.
    res_ready = 1'b1;
    dispatch(1, 1, 0, 0, 32'h4000_0000, 32'h4110_0000);
    step(); idle();
    step();
    check("basic_early", 32'(res_valid), 32'd0);
    step();
    check("basic_valid", 32'(res_valid), 32'd1);
    check("basic_data", res_data, 32'h4190_0000);
    check("basic_tag", 32'(res_tag), 32'd8);
    step();
    check("basic_done", 32'(res_valid), 32'd0);

    // CDB wakeup.
    dispatch(0, 1, 3, 0, 32'd0, 32'h4000_0000);
    step(); idle();
    step(4);
    check("wake_hold_busy", 32'(busy_cnt), 32'd1);
    check("wake_hold_valid", 32'(res_valid), 32'd0);
    bcast(3, 32'h3FC0_0000);
    step(); idle();
    step();
    check("wake_early", 32'(res_valid), 32'd0);
    step();
    check("wake_valid", 32'(res_valid), 32'd1);
    check("wake_data", res_data, 32'h4040_0000);
    step();

    // Same-cycle dispatch/CDB forward.
    dispatch(0, 1, 5, 0, 32'd0, 32'h4080_0000);
    bcast(5, 32'h3F80_0000);
    step(); idle();
    step(2);
    check("fwd_valid", 32'(res_valid), 32'd1);
    check("fwd_data", res_data, 32'h4080_0000);
    step();

    // Full station and backpressure.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vk_tab[i] = 32'h4000_0000 | (32'(i) << 21);
      dispatch(0, 1, 1, 0, 32'd0, vk_tab[i]);
      step();
    end
    idle();
    check("full_disp_ready", 32'(disp_ready), 32'd0);
    check("full_busy_cnt", 32'(busy_cnt), 32'd4);
    bcast(1, 32'h3FC0_0000);
    step(); idle();
    step(5);
    check("bp_busy_cnt", 32'(busy_cnt), 32'd2);
    check("bp_res_valid", 32'(res_valid), 32'd1);
    check("bp_res_tag", 32'(res_tag), 32'd8);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(res_valid), 32'd1);
      check("drain_tag", 32'(res_tag), 32'(TAG_BASE + i));
      check("drain_data", res_data, fpmul(32'h3FC0_0000, vk_tab[i]));
      step();
    end
    check("drain_empty", 32'(res_valid), 32'd0);

    // Ordering: entry 2 dispatched before entry 0, both wake together.
    dispatch(0, 1, 1, 0, 32'd0, 32'h4000_0000); step();
    dispatch(0, 1, 1, 0, 32'd0, 32'h4000_0000); step();
    dispatch(0, 1, 2, 0, 32'd0, 32'h4040_0000); step();
    idle();
    bcast(1, 32'h3F80_0000);
    step(); idle();
    step(6);
    check("ord_alloc_tag", 32'(disp_tag), 32'd8);
    dispatch(0, 1, 2, 0, 32'd0, 32'h40A0_0000);
    step(); idle();
    bcast(2, 32'h4000_0000);
    step(); idle();
`ifdef FPM_RS_AGE_ORDER_EN
    first_tag = 4'd10; first_data = 32'h40C0_0000;
    second_tag = 4'd8; second_data = 32'h4120_0000;
`else
    first_tag = 4'd8; first_data = 32'h4120_0000;
    second_tag = 4'd10; second_data = 32'h40C0_0000;
`endif
    step(2);
    check("ord_first_valid", 32'(res_valid), 32'd1);
    check("ord_first_tag", 32'(res_tag), 32'(first_tag));
    check("ord_first_data", res_data, first_data);
    step();
    check("ord_second_tag", 32'(res_tag), 32'(second_tag));
    check("ord_second_data", res_data, second_data);
    step(2);

    // Flush with busy entries and a pending result.
    res_ready = 1'b0;
    dispatch(1, 1, 0, 0, 32'h4000_0000, 32'h4000_0000);
    step(); idle();
    step(3);
    check("fl_pre_valid", 32'(res_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      dispatch(0, 1, 6, 0, 32'd0, 32'h4000_0000);
      step();
    end
    idle();
    check("fl_pre_busy", 32'(busy_cnt), 32'd3);
    flush = 1'b1;
    dispatch(1, 1, 0, 0, 32'h4000_0000, 32'h4000_0000);
    bcast(6, 32'h3F80_0000);
    step();
    flush = 1'b0; idle();
    check("fl_busy_cnt", 32'(busy_cnt), 32'd0);
    check("fl_res_valid", 32'(res_valid), 32'd0);
    check("fl_disp_ready", 32'(disp_ready), 32'd1);
    check("fl_disp_tag", 32'(disp_tag), 32'd8);
    step(3);
    check("fl_no_ghost", 32'(res_valid), 32'd0);

    // Asynchronous reset in the middle of issue.
    res_ready = 1'b1;
    dispatch(1, 1, 0, 0, 32'h4000_0000, 32'h4040_0000); step();
    dispatch(1, 1, 0, 0, 32'h4000_0000, 32'h4040_0000); step();
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("ar_mul_a", mul_a, 32'd0);
    check("ar_mul_b", mul_b, 32'd0);
    check("ar_busy_cnt", 32'(busy_cnt), 32'd0);
    check("ar_disp_ready", 32'(disp_ready), 32'd1);
    check("ar_disp_tag", 32'(disp_tag), 32'd8);
    check("ar_res_valid", 32'(res_valid), 32'd0);
    check("ar_res_data", res_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Randomized traffic against the scoreboard.
    mon_en = 1'b1;
    for (int c = 0; c < 500; c++) begin
      disp_valid = 1'($urandom_range(1));
      disp_j_rdy = 1'($urandom_range(1));
      disp_k_rdy = 1'($urandom_range(1));
      disp_qj = 4'($urandom_range(3));
      disp_qk = 4'($urandom_range(3));
      disp_vj = rnd_fp();
      disp_vk = rnd_fp();
      cdb_valid = ($urandom_range(2) == 0);
      cdb_tag = 4'($urandom_range(3));
      cdb_data = rnd_fp();
      res_ready = ($urandom_range(3) != 0);
      step();
    end
    disp_valid = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 300 && pend.size() != 0; c++) begin
      bcast(4'(c % 4), rnd_fp());
      step();
    end
    idle();
    step(2);
    mon_en = 1'b0;
    check("rnd_leftover", 32'(pend.size()), 32'd0);
    check("rnd_final_busy", 32'(busy_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fp_mul_rs.md
# fp_mul_rs

Reservation station and issue scheduler for the shared combinational 32-bit floating-point multiplier in the Tomasulo core. It accepts dispatched multiply instructions and holds them until both operands are available, snooping the common data bus (CDB) for missing operands. It issues one ready entry per cycle into a two-stage wrapper around the multiplier (operand register, then result register) and presents results to the CDB arbiter with a valid/ready handshake.

## Interface
- `ENTRIES`, 4: number of station entries (2..8).
- `TAG_W`, 4: width of the producer tag.
- `TAG_BASE`, 8: tag of entry 0; entry i broadcasts tag `TAG_BASE+i`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous squash of all state.
- `disp_valid` in 1: dispatch request.
- `disp_ready` out 1: at least one free entry. Depends on registered state only.
- `disp_j_rdy`, `disp_k_rdy` in 1: the operand value is already present.
- `disp_qj`, `disp_qk` in TAG_W: producer tag, used when the matching rdy flag is 0.
- `disp_vj`, `disp_vk` in 32: operand value, used when the matching rdy flag is 1.
- `disp_tag` out TAG_W: tag assigned to the dispatch in this cycle (the allocated entry).
- `cdb_valid` in 1, `cdb_tag` in TAG_W, `cdb_data` in 32: CDB broadcast.
- `mul_a`, `mul_b` out 32: registered operands to the multiplier.
- `mul_p` in 32: combinational multiplier product.
- `res_valid` out 1, `res_ready` in 1, `res_tag` out TAG_W, `res_data` out 32: result request to the CDB arbiter.
- `busy_cnt` out 4: number of occupied entries.

## Operation
- **Entry state:** busy, j_rdy, k_rdy, qj, qk, vj, vk.
- **Allocation:** lowest-index free entry.
- **Dispatch acceptance:** a dispatch is accepted when `disp_valid & disp_ready`.
- **Dispatch/CDB forwarding:** if a dispatched operand is not ready and its q equals `cdb_tag` while `cdb_valid` is high in the same cycle, the entry stores `cdb_data` with the rdy flag set.
- **Wakeup:** every busy entry with rdy=0 and q==`cdb_tag` under `cdb_valid` captures `cdb_data` and sets rdy. Both operands of one entry can wake on the same broadcast.
- **Ready:** an entry is ready when busy & j_rdy & k_rdy, evaluated on registered state.
- **Selection:** one ready entry per cycle (see Configuration).
- **Pipeline control:**
  - X stage holds `mul_a`, `mul_b`, x_tag, x_valid.
  - W stage holds `res_data`, `res_tag`, `res_valid`.
  - w_adv = !res_valid | res_ready.
  - x_adv = !x_valid | w_adv.
  - issue = any_ready & x_adv.
- **On issue:** the selected entry is freed in the same edge and its vj/vk/tag are loaded into X.
- **On x_adv with x_valid:** W loads `mul_p`, x_tag.
- **Invariant:** W contents hold stable while `res_valid & !res_ready`.
- **Simultaneous dispatch and issue:** a freed entry is not reallocated in the same cycle; `disp_ready` reflects pre-edge state.
- **flush:** clears all busy bits, x_valid, `res_valid`, and age state next edge; dispatch and CDB in that cycle are ignored.
- **Reset values:** all outputs 0; `disp_ready`=1; `disp_tag`=`TAG_BASE`.

## Timing
- **Minimum latency:** dispatch with both operands ready, accepted at edge t. The entry is ready in cycle t+1, issues at edge t+1, `mul_a`/`mul_b` are valid in cycle t+2, and `res_valid` is high in cycle t+3.
- **Wakeup timing:** a CDB capture at edge t makes the entry eligible in cycle t+1.
- **Throughput:** one result per cycle when `res_ready` is held high.
- **Backpressure:** with `res_ready`=0, at most 2 instructions are in flight in the pipeline.
- **Reset:** asserting `rst_n` low mid-operation clears immediately, asynchronously; it is released synchronously by the surrounding reset logic.

## Configuration
- `FPM_RS_AGE_ORDER_EN` defined: each entry keeps an age rank (dispatch order). Selection picks the oldest ready entry. Ranks are compacted on issue.
- `FPM_RS_AGE_ORDER_EN` undefined: selection picks the lowest-index ready entry; no age storage.

## Test plan
- **Basic multiply:** dispatch vj=0x40000000, vk=0x41100000 (2.0×9.0), both rdy, `res_ready`=1 -> `res_valid` 3 cycles later, `res_data`=0x41900000, `res_tag`=8.
- **CDB wakeup:** dispatch j_rdy=0 qj=3, vk=0x40000000; hold 4 cycles, no issue, `busy_cnt`=1. Then cdb tag 3 data 0x3FC00000 -> `res_data`=0x40400000 three cycles after the broadcast.
- **Dispatch/CDB forward:** dispatch qj=5 with `cdb_valid` tag 5 data 0x3F800000 in the same cycle, vk=0x40800000 -> result 0x40800000 at minimum latency.
- **Full and backpressure:**
  - fill 4 entries -> `disp_ready`=0;
  - hold `res_ready`=0 -> exactly 2 issues, `busy_cnt`=2;
  - release -> remaining results drain at one per cycle.
- **Ordering:** entries 2 then 0 become ready in the same cycle.
  - With `FPM_RS_AGE_ORDER_EN`, where entry 2 was dispatched first -> tag 10 issued first.
  - Without -> tag 8 issued first.
- **Flush and reset:**
  - flush with 3 busy entries and `res_valid`=1 -> next cycle `busy_cnt`=0, `res_valid`=0;
  - `rst_n` low mid-issue -> all outputs 0 and `disp_ready`=1 before the next edge.
